// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard sequencer: FSM states and branch funct3 encodings.
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT_ERR = 2'd2
    } state_t;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard sequencer bundle: stage observations in, stall/flush/redirect controls out.
interface hazard_ctrl_if #(
    parameter int CntWidth = 32
);
    logic [4:0]          id_rs1_i;
    logic [4:0]          id_rs2_i;
    logic                id_uses_rs1_i;
    logic                id_uses_rs2_i;
    logic [4:0]          dx_rd_i;
    logic                dx_MemRead_i;
    logic                xm_branch_i;
    logic [2:0]          xm_funct3_i;
    logic                xm_zero_i;
    logic                xm_ltz_i;
    logic [63:0]         xm_BranchPC_i;
    logic                xm_MemRead_i;
    logic                xm_MemWrite_i;
    logic                dmem_ack_i;

    logic                pc_we_o;
    logic                pc_sel_o;
    logic [63:0]         pc_target_o;
    logic                fd_stall_o;
    logic                dx_stall_o;
    logic                xm_stall_o;
    logic                fd_flush_o;
    logic                dx_flush_o;
    logic                xm_flush_o;
    logic                mw_flush_o;
    logic                err_o;
    logic [CntWidth-1:0] stall_cycles_o;
    logic [CntWidth-1:0] flush_count_o;

    // Sequencer side.
    modport master (
        input  id_rs1_i, id_rs2_i, id_uses_rs1_i, id_uses_rs2_i,
        input  dx_rd_i, dx_MemRead_i,
        input  xm_branch_i, xm_funct3_i, xm_zero_i, xm_ltz_i, xm_BranchPC_i,
        input  xm_MemRead_i, xm_MemWrite_i, dmem_ack_i,
        output pc_we_o, pc_sel_o, pc_target_o,
        output fd_stall_o, dx_stall_o, xm_stall_o,
        output fd_flush_o, dx_flush_o, xm_flush_o, mw_flush_o,
        output err_o, stall_cycles_o, flush_count_o
    );

    // Pipeline side.
    modport slave (
        output id_rs1_i, id_rs2_i, id_uses_rs1_i, id_uses_rs2_i,
        output dx_rd_i, dx_MemRead_i,
        output xm_branch_i, xm_funct3_i, xm_zero_i, xm_ltz_i, xm_BranchPC_i,
        output xm_MemRead_i, xm_MemWrite_i, dmem_ack_i,
        input  pc_we_o, pc_sel_o, pc_target_o,
        input  fd_stall_o, dx_stall_o, xm_stall_o,
        input  fd_flush_o, dx_flush_o, xm_flush_o, mw_flush_o,
        input  err_o, stall_cycles_o, flush_count_o
    );

endinterface

// File: rtl/hazard_ctrl_branch_cond.sv
// Combinational branch condition from funct3 and ALU flags; 110/111 rely on the ALU's unsigned ltz.
module branch_cond
    import hazard_ctrl_pkg::*;
(
    input  logic [2:0] funct3_i,
    input  logic       zero_i,
    input  logic       ltz_i,
    output logic       taken_o
);

    always_comb begin
        taken_o = 1'b0;
        case (funct3_i)
            F3_BEQ:           taken_o = zero_i;
            F3_BNE:           taken_o = ~zero_i;
            F3_BLT, F3_BLTU:  taken_o = ltz_i;
            F3_BGE, F3_BGEU:  taken_o = ~ltz_i;
            default:          taken_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer: load-use bubbles, XM branch redirects, data-memory wait with watchdog.
// All controls are combinational from state and stage inputs; state and counters advance on clk_i.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MemTimeout = 16,
    parameter int CntWidth   = 32
) (
    input  logic          clk_i,
    input  logic          reset_ni,
    hazard_ctrl_if.master hz
);

    localparam int WdWidth = (MemTimeout > 2) ? $clog2(MemTimeout) : 1;
    localparam logic [WdWidth-1:0] WdLast = WdWidth'(MemTimeout - 1);

    state_t              state_q, state_d;
    logic [WdWidth-1:0]  wd_q, wd_d, wd_inc;
    logic [CntWidth-1:0] stall_cnt_q, stall_cnt_d;
    logic [CntWidth-1:0] flush_cnt_q, flush_cnt_d;

    logic cond_taken, taken, load_use, mem_pend, use_run, freeze;
    logic pc_we, pc_sel, redirect, err;
    logic fd_stall, dx_stall, xm_stall;
    logic fd_flush, dx_flush, xm_flush, mw_flush;
    logic [63:0] pc_target;

    branch_cond u_branch_cond (
        .funct3_i (hz.xm_funct3_i),
        .zero_i   (hz.xm_zero_i),
        .ltz_i    (hz.xm_ltz_i),
        .taken_o  (cond_taken)
    );

    assign taken    = hz.xm_branch_i & cond_taken;
    assign load_use = hz.dx_MemRead_i & (hz.dx_rd_i != 5'd0) &
                      ((hz.id_uses_rs1_i & (hz.id_rs1_i == hz.dx_rd_i)) |
                       (hz.id_uses_rs2_i & (hz.id_rs2_i == hz.dx_rd_i)));
    assign mem_pend = (hz.xm_MemRead_i | hz.xm_MemWrite_i) & ~hz.dmem_ack_i;

    // The ack cycle of a wait behaves exactly like a RUN cycle.
    assign use_run = (state_q == RUN) | ((state_q == MEM_WAIT) & hz.dmem_ack_i);
    assign freeze  = ~use_run | mem_pend;
    assign wd_inc  = wd_q + WdWidth'(1);

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= RUN;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wd_d    = wd_q;
        case (state_q)
            RUN: begin
                if (mem_pend) begin
                    state_d = MEM_WAIT;
                    wd_d    = '0;
                end
            end
            MEM_WAIT: begin
                if (hz.dmem_ack_i) begin
                    state_d = RUN;
                    wd_d    = '0;
                end else begin
                    wd_d = wd_inc;
                    if (wd_inc == WdLast) begin
                        state_d = HALT_ERR;
                    end
                end
            end
            HALT_ERR: state_d = HALT_ERR;
            default:  state_d = RUN;
        endcase
    end

    always_comb begin
        pc_we     = 1'b1;
        pc_sel    = 1'b0;
        pc_target = 64'd0;
        redirect  = 1'b0;
        err       = 1'b0;
        fd_stall  = 1'b0;
        dx_stall  = 1'b0;
        xm_stall  = 1'b0;
        fd_flush  = 1'b0;
        dx_flush  = 1'b0;
        xm_flush  = 1'b0;
        mw_flush  = 1'b0;
        if (!reset_ni) begin
            pc_we    = 1'b0;
            fd_flush = 1'b1;
            dx_flush = 1'b1;
            xm_flush = 1'b1;
            mw_flush = 1'b1;
        end else if (freeze) begin
            pc_we    = 1'b0;
            fd_stall = 1'b1;
            dx_stall = 1'b1;
            xm_stall = 1'b1;
            mw_flush = 1'b1;
            err      = (state_q == HALT_ERR);
        end else if (taken) begin
            pc_sel    = 1'b1;
            pc_target = hz.xm_BranchPC_i;
            redirect  = 1'b1;
            fd_flush  = 1'b1;
            dx_flush  = 1'b1;
            xm_flush  = 1'b1;
        end else if (load_use) begin
            pc_we    = 1'b0;
            fd_stall = 1'b1;
            dx_flush = 1'b1;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!pc_we && (stall_cnt_q != {CntWidth{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CntWidth'(1);
        end
        if (redirect && (flush_cnt_q != {CntWidth{1'b1}})) begin
            flush_cnt_d = flush_cnt_q + CntWidth'(1);
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign hz.pc_we_o        = pc_we;
    assign hz.pc_sel_o       = pc_sel;
    assign hz.pc_target_o    = pc_target;
    assign hz.fd_stall_o     = fd_stall;
    assign hz.dx_stall_o     = dx_stall;
    assign hz.xm_stall_o     = xm_stall;
    assign hz.fd_flush_o     = fd_flush;
    assign hz.dx_flush_o     = dx_flush;
    assign hz.xm_flush_o     = xm_flush;
    assign hz.mw_flush_o     = mw_flush;
    assign hz.err_o          = err;
    assign hz.stall_cycles_o = stall_cnt_q;
    assign hz.flush_count_o  = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with MemTimeout=4 and CntWidth=4.
`timescale 1ns/1ps
module tb_hazard_ctrl;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_pass;

    hazard_ctrl_if #(.CntWidth(4)) bus ();

    hazard_ctrl #(
        .MemTimeout (4),
        .CntWidth   (4)
    ) dut (
        .clk_i    (clk),
        .reset_ni (rst_n),
        .hz       (bus)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // {pc_we, pc_sel, fd/dx/xm_stall, fd/dx/xm/mw_flush, err}
    localparam logic [9:0] C_RESET = 10'b0_0_000_1111_0;
    localparam logic [9:0] C_RUN   = 10'b1_0_000_0000_0;
    localparam logic [9:0] C_LU    = 10'b0_0_100_0100_0;
    localparam logic [9:0] C_BR    = 10'b1_1_000_1110_0;
    localparam logic [9:0] C_FRZ   = 10'b0_0_111_0001_0;
    localparam logic [9:0] C_HALT  = 10'b0_0_111_0001_1;

    function automatic logic [9:0] ctl();
        return {bus.pc_we_o, bus.pc_sel_o,
                bus.fd_stall_o, bus.dx_stall_o, bus.xm_stall_o,
                bus.fd_flush_o, bus.dx_flush_o, bus.xm_flush_o, bus.mw_flush_o,
                bus.err_o};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        bus.id_rs1_i      = '0;
        bus.id_rs2_i      = '0;
        bus.id_uses_rs1_i = 1'b0;
        bus.id_uses_rs2_i = 1'b0;
        bus.dx_rd_i       = '0;
        bus.dx_MemRead_i  = 1'b0;
        bus.xm_branch_i   = 1'b0;
        bus.xm_funct3_i   = '0;
        bus.xm_zero_i     = 1'b0;
        bus.xm_ltz_i      = 1'b0;
        bus.xm_BranchPC_i = '0;
        bus.xm_MemRead_i  = 1'b0;
        bus.xm_MemWrite_i = 1'b0;
        bus.dmem_ack_i    = 1'b0;
    endtask

    task automatic set_lu();
        bus.dx_MemRead_i  = 1'b1;
        bus.dx_rd_i       = 5'd5;
        bus.id_rs2_i      = 5'd5;
        bus.id_uses_rs2_i = 1'b1;
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        clr_in();
        rst_n = 1'b0;

        // Reset values
        #3;
        chk("rst_ctl",   64'(ctl()), 64'(C_RESET));
        chk("rst_tgt",   bus.pc_target_o, 64'd0);
        chk("rst_stall", 64'(bus.stall_cycles_o), 64'd0);
        chk("rst_flush", 64'(bus.flush_count_o), 64'd0);
        #9 rst_n = 1'b1;
        #1 chk("run_idle", 64'(ctl()), 64'(C_RUN));
        tick();

        // Load-use: one bubble, one stall cycle
        set_lu();
        #1 chk("lu_ctl", 64'(ctl()), 64'(C_LU));
        tick();
        chk("lu_cnt", 64'(bus.stall_cycles_o), 64'd1);
        bus.dx_MemRead_i = 1'b0;
        #1 chk("lu_clear", 64'(ctl()), 64'(C_RUN));
        bus.dx_MemRead_i = 1'b1; bus.dx_rd_i = 5'd0; bus.id_rs2_i = 5'd0;
        #1 chk("lu_rd0", 64'(ctl()), 64'(C_RUN));
        bus.dx_rd_i = 5'd7; bus.id_rs1_i = 5'd7; bus.id_uses_rs1_i = 1'b1; bus.id_uses_rs2_i = 1'b0;
        #1 chk("lu_rs1", 64'(ctl()), 64'(C_LU));
        bus.id_uses_rs1_i = 1'b0;
        #1 chk("lu_nouse", 64'(ctl()), 64'(C_RUN));
        clr_in();
        tick();
        chk("lu_once", 64'(bus.stall_cycles_o), 64'd1);

        // Taken BNE overrides load-use
        set_lu();
        bus.xm_branch_i = 1'b1; bus.xm_funct3_i = 3'b001; bus.xm_zero_i = 1'b0;
        bus.xm_BranchPC_i = 64'h1000;
        #1 chk("bne_ctl", 64'(ctl()), 64'(C_BR));
        chk("bne_tgt", bus.pc_target_o, 64'h1000);
        tick();
        chk("bne_fcnt", 64'(bus.flush_count_o), 64'd1);
        chk("bne_scnt", 64'(bus.stall_cycles_o), 64'd1);
        bus.xm_zero_i = 1'b1;
        #1 chk("bne_nt", 64'(ctl()), 64'(C_LU));
        bus.xm_funct3_i = 3'b000;
        #1 chk("beq_t", 64'(ctl()), 64'(C_BR));
        bus.xm_funct3_i = 3'b010;
        #1 chk("f3_010", 64'(ctl()), 64'(C_LU));
        bus.xm_funct3_i = 3'b101; bus.xm_zero_i = 1'b0; bus.xm_ltz_i = 1'b0;
        #1 chk("bge_t", 64'(ctl()), 64'(C_BR));
        bus.xm_funct3_i = 3'b110; bus.xm_ltz_i = 1'b1;
        #1 chk("bltu_t", 64'(ctl()), 64'(C_BR));
        bus.xm_ltz_i = 1'b0;
        #1 chk("bltu_nt", 64'(ctl()), 64'(C_LU));
        bus.xm_branch_i = 1'b0; bus.xm_funct3_i = 3'b000; bus.xm_zero_i = 1'b1;
        #1 chk("nobranch", 64'(ctl()), 64'(C_LU));
        clr_in();

        // Synchronous-looking reset pulse clears counters
        rst_n = 1'b0;
        #1 chk("pulse_scnt", 64'(bus.stall_cycles_o), 64'd0);
        chk("pulse_fcnt", 64'(bus.flush_count_o), 64'd0);
        #1 rst_n = 1'b1;
        tick();

        // Ack in request cycle: no stall
        bus.xm_MemRead_i = 1'b1; bus.dmem_ack_i = 1'b1;
        #1 chk("ack0_ctl", 64'(ctl()), 64'(C_RUN));
        tick();
        chk("ack0_cnt", 64'(bus.stall_cycles_o), 64'd0);

        // Memory wait: three frozen cycles, release on ack
        bus.dmem_ack_i = 1'b0;
        #1 chk("mw_c1", 64'(ctl()), 64'(C_FRZ));
        tick();
        chk("mw_c2", 64'(ctl()), 64'(C_FRZ));
        tick();
        chk("mw_c3", 64'(ctl()), 64'(C_FRZ));
        chk("mw_cnt2", 64'(bus.stall_cycles_o), 64'd2);
        tick();
        chk("mw_cnt3", 64'(bus.stall_cycles_o), 64'd3);
        bus.dmem_ack_i = 1'b1;
        #1 chk("mw_rel", 64'(ctl()), 64'(C_RUN));
        tick();
        clr_in();
        #1 chk("mw_run", 64'(ctl()), 64'(C_RUN));
        chk("mw_hold", 64'(bus.stall_cycles_o), 64'd3);

        // Watchdog timeout after four wait cycles
        bus.xm_MemRead_i = 1'b1;
        tick();
        tick();
        tick();
        chk("to_last", 64'(ctl()), 64'(C_FRZ));
        tick();
        chk("to_halt", 64'(ctl()), 64'(C_HALT));
        chk("to_cnt", 64'(bus.stall_cycles_o), 64'd7);
        bus.dmem_ack_i = 1'b1;
        tick();
        tick();
        chk("to_ackign", 64'(ctl()), 64'(C_HALT));
        clr_in();
        tick();
        chk("to_sticky", 64'(ctl()), 64'(C_HALT));

        // Stall counter saturates at 15
        repeat (20) tick();
        chk("sat", 64'(bus.stall_cycles_o), 64'd15);
        chk("sat_halt", 64'(ctl()), 64'(C_HALT));

        // Reset leaves HALT_ERR
        rst_n = 1'b0;
        #1 chk("halt_rst", 64'(ctl()), 64'(C_RESET));
        #1 rst_n = 1'b1;
        #1 chk("halt_out", 64'(ctl()), 64'(C_RUN));
        tick();

        // Asynchronous reset in the middle of a wait
        bus.xm_MemRead_i = 1'b1;
        tick();
        tick();
        chk("mr_wait", 64'(ctl()), 64'(C_FRZ));
        #3 rst_n = 1'b0;
        #1 chk("mr_ctl", 64'(ctl()), 64'(C_RESET));
        chk("mr_scnt", 64'(bus.stall_cycles_o), 64'd0);
        chk("mr_tgt", bus.pc_target_o, 64'd0);
        tick();
        bus.xm_MemRead_i = 1'b0;
        #3 rst_n = 1'b1;
        #1 chk("mr_run", 64'(ctl()), 64'(C_RUN));
        tick();
        chk("mr_run2", 64'(ctl()), 64'(C_RUN));
        chk("mr_cnt0", 64'(bus.stall_cycles_o), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
